// File: rtl/me_pixel_feeder_pkg.sv
// Shared constants and state encoding for the motion-estimation pixel feeder.
// The block edge, its square and cube define the beat count of one full search.
package me_pixel_feeder_pkg;

  localparam int BLK_SIZE = 8;
  localparam int BS_SQ    = BLK_SIZE * BLK_SIZE;
  localparam int BS_CUBE  = BS_SQ * BLK_SIZE;
  localparam int COORD_W  = 10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/me_pixel_feeder_addr_clamp.sv
// Combinational edge-replicating address generator: clamps a signed (x, y)
// into the frame and returns the linear pixel address y*FRAME_W + x.
module me_addr_clamp
  import me_pixel_feeder_pkg::*;
#(
  parameter int FRAME_W = 64,
  parameter int FRAME_H = 64,
  parameter int ADDR_W  = 12
) (
  input  logic signed [COORD_W-1:0] x,
  input  logic signed [COORD_W-1:0] y,
  output logic        [ADDR_W-1:0]  addr
);

  localparam logic signed [COORD_W-1:0] X_MAX = COORD_W'(FRAME_W - 1);
  localparam logic signed [COORD_W-1:0] Y_MAX = COORD_W'(FRAME_H - 1);

  logic [COORD_W-1:0] cx;
  logic [COORD_W-1:0] cy;

  always_comb begin
    if (x < 0)
      cx = '0;
    else if (x > X_MAX)
      cx = X_MAX;
    else
      cx = x;

    if (y < 0)
      cy = '0;
    else if (y > Y_MAX)
      cy = Y_MAX;
    else
      cy = y;

    addr = ADDR_W'(32'(cy) * FRAME_W + 32'(cx));
  end

endmodule

// File: rtl/me_pixel_feeder.sv
// Fetches the current block and the two reference search pixels per beat from
// 1-cycle-latency SRAMs and streams BLK_SIZE^3 beats to the SAD PE row per go.
module me_pixel_feeder
  import me_pixel_feeder_pkg::*;
#(
  parameter int FRAME_W = 64,
  parameter int FRAME_H = 64,
  parameter int ADDR_W  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [7:0]        blk_x,
  input  logic [7:0]        blk_y,
  output logic              cur_rd,
  output logic [ADDR_W-1:0] cur_addr,
  input  logic [7:0]        cur_data,
  output logic              ref_rd,
  output logic [ADDR_W-1:0] ref_addr,
  output logic [ADDR_W-1:0] ref_addr_hi,
  input  logic [15:0]       ref_data,
  output logic [7:0]        c,
  output logic [7:0]        p,
  output logic [7:0]        p_prime,
  output logic              start,
  output logic              valid,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W   = $clog2(BLK_SIZE);
  localparam int BEAT_W  = 3 * CNT_W;
  localparam int N_CLAMP = 3;
  localparam int CL_CUR  = 0;
  localparam int CL_LO   = 1;
  localparam int CL_HI   = 2;

  localparam logic signed [COORD_W-1:0] HALF = COORD_W'(BLK_SIZE / 2);
  localparam logic signed [COORD_W-1:0] BS_S = COORD_W'(BLK_SIZE);

  state_t state_reg, state_next;

  logic [BEAT_W-1:0] beat_reg;
  logic [7:0]        blk_x_reg;
  logic [7:0]        blk_y_reg;
  logic              valid_reg;
  logic              start_reg;
  logic              issue;
  logic              last_beat;

  logic [CNT_W-1:0] col, row, mi;
  logic signed [COORD_W-1:0] bx, by, col_s, row_s, mi_s;

  logic signed [COORD_W-1:0] clamp_x    [N_CLAMP];
  logic signed [COORD_W-1:0] clamp_y    [N_CLAMP];
  logic        [ADDR_W-1:0]  clamp_addr [N_CLAMP];

  // A single beat counter: col in the low bits wraps into row, row into mi.
  assign col = beat_reg[CNT_W-1:0];
  assign row = beat_reg[2*CNT_W-1:CNT_W];
  assign mi  = beat_reg[BEAT_W-1:2*CNT_W];
  assign last_beat = (beat_reg == BEAT_W'(BS_CUBE - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (go) state_next = FETCH;
      FETCH:   state_next = STREAM;
      STREAM:  if (last_beat) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    issue = (state_reg == FETCH) || (state_reg == STREAM);
    busy  = (state_reg != IDLE);
    done  = (state_reg == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_reg  <= '0;
      blk_x_reg <= '0;
      blk_y_reg <= '0;
      valid_reg <= 1'b0;
      start_reg <= 1'b0;
    end else begin
      if (state_reg == IDLE && go) begin
        blk_x_reg <= blk_x;
        blk_y_reg <= blk_y;
      end
      beat_reg  <= issue ? beat_reg + BEAT_W'(1) : '0;
      valid_reg <= issue;
      start_reg <= (state_reg == FETCH);
    end
  end

  assign bx    = signed'(COORD_W'(blk_x_reg));
  assign by    = signed'(COORD_W'(blk_y_reg));
  assign col_s = signed'(COORD_W'(col));
  assign row_s = signed'(COORD_W'(row));
  assign mi_s  = signed'(COORD_W'(mi));

  assign clamp_x[CL_CUR] = bx + col_s;
  assign clamp_y[CL_CUR] = by + row_s;
  assign clamp_x[CL_LO]  = bx - HALF + col_s;
  assign clamp_y[CL_LO]  = by - HALF + mi_s + row_s;
  assign clamp_x[CL_HI]  = bx - HALF + col_s + BS_S;
  assign clamp_y[CL_HI]  = by - HALF + mi_s + row_s;

  generate
    for (genvar gi = 0; gi < N_CLAMP; gi++) begin : g_clamp
      me_addr_clamp #(
        .FRAME_W (FRAME_W),
        .FRAME_H (FRAME_H),
        .ADDR_W  (ADDR_W)
      ) u_clamp (
        .x    (clamp_x[gi]),
        .y    (clamp_y[gi]),
        .addr (clamp_addr[gi])
      );
    end
  endgenerate

  assign cur_rd      = issue;
  assign ref_rd      = issue;
  assign cur_addr    = issue ? clamp_addr[CL_CUR] : '0;
  assign ref_addr    = issue ? clamp_addr[CL_LO]  : '0;
  assign ref_addr_hi = issue ? clamp_addr[CL_HI]  : '0;

  // The SRAM read registers act as the stream pipeline stage; gating by the
  // registered valid keeps the outputs at zero outside a run and under reset.
  assign c       = valid_reg ? cur_data       : '0;
  assign p_prime = valid_reg ? ref_data[7:0]  : '0;
  assign p       = valid_reg ? ref_data[15:8] : '0;
  assign valid   = valid_reg;
  assign start   = start_reg;

endmodule

// File: tb/tb_me_pixel_feeder.sv
// Scoreboard bench for me_pixel_feeder: SRAM models serve pixel(x,y)=(x+3y)&255,
// a coordinate-level model queues expected beats, a monitor pops and compares.
module tb_me_pixel_feeder;
  import me_pixel_feeder_pkg::*;

  localparam int FW = 64;
  localparam int FH = 64;
  localparam int AW = 12;
  localparam int T  = BS_CUBE;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          go = 1'b0;
  logic [7:0]    blk_x = '0;
  logic [7:0]    blk_y = '0;
  logic          cur_rd, ref_rd;
  logic [AW-1:0] cur_addr, ref_addr, ref_addr_hi;
  logic [7:0]    cur_data = '0;
  logic [15:0]   ref_data = '0;
  logic [7:0]    c, p, p_prime;
  logic          start, valid, busy, done;

  me_pixel_feeder #(.FRAME_W(FW), .FRAME_H(FH), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .go(go), .blk_x(blk_x), .blk_y(blk_y),
    .cur_rd(cur_rd), .cur_addr(cur_addr), .cur_data(cur_data),
    .ref_rd(ref_rd), .ref_addr(ref_addr), .ref_addr_hi(ref_addr_hi),
    .ref_data(ref_data), .c(c), .p(p), .p_prime(p_prime),
    .start(start), .valid(valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { int c; int p; int pp; bit first; } beat_t;
  beat_t sb[$];

  int total = 0, bad = 0;
  int cyc = 0, beats = 0, rd_cnt = 0, done_cnt = 0;
  int done_cyc = -1, start_cyc = -1, exp_start_cyc = -1;
  bit prev_valid = 1'b0;

  function automatic int pix(int x, int y);
    return (x + 3 * y) & 255;
  endfunction

  function automatic int clampi(int v, int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  function automatic int pix_of_addr(int a);
    return pix(a % FW, a / FW);
  endfunction

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected stream for one search, straight from the coordinate rules.
  task automatic push_run(int bx, int by);
    beat_t e;
    for (int t = 0; t < T; t++) begin
      int mi = t / BS_SQ;
      int row = (t / BLK_SIZE) % BLK_SIZE;
      int col = t % BLK_SIZE;
      int ry = clampi(by - BLK_SIZE / 2 + mi + row, FH - 1);
      int rx = bx - BLK_SIZE / 2 + col;
      e.c = pix(clampi(bx + col, FW - 1), clampi(by + row, FH - 1));
      e.pp = pix(clampi(rx, FW - 1), ry);
      e.p = pix(clampi(rx + BLK_SIZE, FW - 1), ry);
      e.first = (t == 0);
      sb.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    if (cur_rd) cur_data <= 8'(pix_of_addr(int'(cur_addr)));
    if (ref_rd) ref_data <= {8'(pix_of_addr(int'(ref_addr_hi))), 8'(pix_of_addr(int'(ref_addr)))};
  end

  always @(posedge clk) begin
    beat_t e;
    #1;
    cyc++;
    if (!reset) begin
      if (cur_rd) rd_cnt++;
      if (valid) begin
        if (sb.size() == 0) begin
          check("extra_beat", 1, 0);
        end else begin
          e = sb.pop_front();
          check("c", int'(c), e.c);
          check("p_prime", int'(p_prime), e.pp);
          check("p", int'(p), e.p);
          check("start_flag", int'(start), int'(e.first));
          if (e.first) begin
            start_cyc = cyc;
            check("start_cycle", cyc, exp_start_cyc);
          end
          beats++;
        end
      end else if (start) begin
        check("start_without_valid", 1, 0);
      end
      if (done) begin
        check("beats_per_run", beats, T);
        check("rd_cycles", rd_cnt, T);
        check("done_after_last_beat", int'(prev_valid), 1);
        check("valid_in_done", int'(valid), 0);
        beats = 0;
        rd_cnt = 0;
        done_cnt++;
        done_cyc = cyc;
      end
      prev_valid = valid;
    end
  end

  // Call at a negedge; leaves the caller at the following negedge.
  task automatic start_run(int bx, int by);
    blk_x = 8'(bx);
    blk_y = 8'(by);
    go = 1'b1;
    exp_start_cyc = cyc + 2;
    push_run(bx, by);
    @(negedge clk);
    go = 1'b0;
    blk_x = 8'($urandom_range(0, 255));
    blk_y = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_done(string name);
    int n0 = done_cnt;
    for (int i = 0; i < T + 50 && done_cnt == n0; i++) @(negedge clk);
    check(name, done_cnt, n0 + 1);
  endtask

  task automatic wait_beats(int n);
    for (int i = 0; i < T + 50 && beats < n; i++) @(negedge clk);
    check("beat_wait", int'(beats >= n), 1);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_valid"}, int'(valid), 0);
    check({tag, "_start"}, int'(start), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_pix"}, int'({c, p, p_prime}), 0);
    check({tag, "_rd"}, int'({cur_rd, ref_rd}), 0);
    check({tag, "_addr"}, int'({cur_addr, ref_addr, ref_addr_hi}), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d1, n0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    start_run(24, 24);
    check("busy_in_run", int'(busy), 1);
    wait_done("done_blk24");
    @(negedge clk);
    check("busy_after_run", int'(busy), 0);

    start_run(0, 0);
    wait_done("done_blk0");
    @(negedge clk);

    start_run(56, 56);
    wait_done("done_blk56");
    @(negedge clk);

    start_run(33, 17);
    wait_beats(10);
    go = 1'b1; blk_x = 8'd3; blk_y = 8'd3;
    @(negedge clk); go = 1'b0;
    wait_beats(300);
    go = 1'b1;
    @(negedge clk); go = 1'b0;
    wait_done("done_ignored_go");
    go = 1'b1;
    @(negedge clk); go = 1'b0;
    repeat (3) @(negedge clk);
    check("go_in_done_ignored", int'(busy), 0);

    start_run(40, 8);
    wait_beats(200);
    n0 = done_cnt;
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset");
    sb.delete();
    beats = 0;
    rd_cnt = 0;
    prev_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("no_done_on_abort", done_cnt, n0);
    check("idle_after_abort", int'(busy), 0);
    start_run(10, 50);
    wait_done("done_after_abort");
    @(negedge clk);

    start_run(5, 60);
    wait_done("done_b2b_first");
    d1 = done_cyc;
    @(negedge clk);
    start_run(60, 3);
    wait_beats(1);
    check("b2b_start_gap", start_cyc - d1, 3);
    wait_done("done_b2b_second");
    @(negedge clk);

    for (int r = 0; r < 3; r++) begin
      start_run(int'($urandom_range(0, 80)), int'($urandom_range(0, 80)));
      wait_done("done_random");
      @(negedge clk);
    end

    repeat (2) @(negedge clk);
    check("queue_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
